// File: rtl/pdm_fir_pkg.sv
// Shared constants, types, coefficient table and FSM states for the decimating PDM FIR.
// The coefficients form a symmetric triangular low-pass whose taps sum to exactly 32768 (unity DC gain in Q1.15).
package pdm_fir_pkg;

   localparam int NTAPS     = 51;
   localparam int COEF_W    = 16;
   localparam int ACC_W     = 24;
   localparam int OUT_W     = 16;
   localparam int DECIM_DEF = 32;
   localparam int KW        = $clog2(NTAPS);
   localparam int COEF_SUM  = 32768;

   typedef logic signed [COEF_W-1:0] coef_t;
   typedef logic signed [ACC_W-1:0]  acc_t;

   // 48 * (26 - |k - 25|), with the 320-unit remainder folded into the centre tap.
   localparam coef_t COEF [NTAPS] = '{
      16'sd48,   16'sd96,   16'sd144,  16'sd192,  16'sd240,  16'sd288,  16'sd336,
      16'sd384,  16'sd432,  16'sd480,  16'sd528,  16'sd576,  16'sd624,  16'sd672,
      16'sd720,  16'sd768,  16'sd816,  16'sd864,  16'sd912,  16'sd960,  16'sd1008,
      16'sd1056, 16'sd1104, 16'sd1152, 16'sd1200,
      16'sd1568,
      16'sd1200, 16'sd1152, 16'sd1104, 16'sd1056, 16'sd1008, 16'sd960,  16'sd912,
      16'sd864,  16'sd816,  16'sd768,  16'sd720,  16'sd672,  16'sd624,  16'sd576,
      16'sd528,  16'sd480,  16'sd432,  16'sd384,  16'sd336,  16'sd288,  16'sd240,
      16'sd192,  16'sd144,  16'sd96,   16'sd48
   };

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      OUT   = 2'd2
   } state_t;

endpackage

// File: rtl/pdm_fir_decim_if.sv
// Bundle between the PDM shift register / PCM consumer (master) and the FIR decimator (slave).
// No backpressure: ready_in is a strobe and sample_valid a single-cycle pulse.
interface pdm_fir_decim_if;
   import pdm_fir_pkg::*;

   logic                    ready_in;
   logic [NTAPS-1:0]        shiftreg_in;
   logic signed [OUT_W-1:0] sample_out;
   logic                    sample_valid;
   logic                    busy;
   logic                    overrun;

   modport master (
      output ready_in, shiftreg_in,
      input  sample_out, sample_valid, busy, overrun
   );

   modport slave (
      input  ready_in, shiftreg_in,
      output sample_out, sample_valid, busy, overrun
   );
endinterface

// File: rtl/pdm_fir_coef_rom.sv
// Combinational coefficient lookup: tap index k -> signed Q1.15 coefficient; zero latency, no handshake.
// Indices past the last tap return zero so the accumulator is never fed garbage.
module pdm_fir_coef_rom
   import pdm_fir_pkg::*;
(
   input  logic [KW-1:0] k,
   output coef_t         coef
);
   assign coef = (k < KW'(NTAPS)) ? COEF[k] : '0;
endmodule

// File: rtl/pdm_fir_decim.sv
// Decimating FIR over the PDM window: one PCM sample per DECIM ready_in strobes, NTAPS+1 clocks after the trigger.
// No backpressure: a trigger while busy is dropped and sets sticky overrun. PDM_FIR_SATURATE_EN clamps instead of wrapping.
module pdm_fir_decim
   import pdm_fir_pkg::*;
#(
   parameter int DECIM = DECIM_DEF
) (
   input  logic           clk,
   input  logic           reset,
   pdm_fir_decim_if.slave bus
);
   localparam int            DW        = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [DW-1:0] DCNT_LAST = DW'(DECIM - 1);
   localparam logic [KW-1:0] K_LAST    = KW'(NTAPS - 1);

   state_t                  state;
   state_t                  state_n;
   logic [DW-1:0]           dcnt;
   logic [KW-1:0]           k;
   logic [NTAPS-1:0]        win;
   acc_t                    acc;
   coef_t                   coef;
   acc_t                    coef_ext;
   logic signed [OUT_W-1:0] conv;
   logic                    trig;

   assign trig     = bus.ready_in && (dcnt == DCNT_LAST);
   assign bus.busy = (state != IDLE);
   assign coef_ext = {{(ACC_W-COEF_W){coef[COEF_W-1]}}, coef};

   pdm_fir_coef_rom u_rom (
      .k    (k),
      .coef (coef)
   );

`ifdef PDM_FIR_SATURATE_EN
   localparam acc_t                    SAT_MAX = acc_t'((2 ** (OUT_W - 1)) - 1);
   localparam acc_t                    SAT_MIN = acc_t'(-(2 ** (OUT_W - 1)));
   localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

   always_comb begin
      conv = acc[OUT_W-1:0];
      if (acc > SAT_MAX) begin
         conv = OUT_MAX;
      end else if (acc < SAT_MIN) begin
         conv = OUT_MIN;
      end
   end
`else
   always_comb begin
      conv = acc[OUT_W-1:0];
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (trig) state_n = ACCUM;
         ACCUM:   if (k == K_LAST) state_n = OUT;
         OUT:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dcnt             <= '0;
         k                <= '0;
         win              <= '0;
         acc              <= '0;
         bus.sample_out   <= '0;
         bus.sample_valid <= 1'b0;
         bus.overrun      <= 1'b0;
      end else begin
         // The decimation phase keeps counting while busy so the output rate stays locked to the PDM clock.
         if (bus.ready_in) begin
            dcnt <= (dcnt == DCNT_LAST) ? '0 : dcnt + DW'(1);
         end
         if (trig && (state != IDLE)) begin
            bus.overrun <= 1'b1;
         end
         bus.sample_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (trig) begin
                  win <= bus.shiftreg_in;
                  acc <= '0;
                  k   <= '0;
               end
            end
            ACCUM: begin
               acc <= acc + (win[k] ? coef_ext : -coef_ext);
               k   <= k + KW'(1);
            end
            OUT: begin
               bus.sample_out   <= conv;
               bus.sample_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule
